// File: rtl/matrix_result_serializer.sv
// Ping-pong buffer behind the matrix multiplier. Each result matrix is captured
// whole and streamed out row-major, one element per valid/ready beat.
module matrix_result_serializer #(
  parameter int DATA_WIDTH       = 8,
  parameter int A_ROWS           = 8,
  parameter int B_COLUMNS        = 5,
  parameter int A_COLUMNS_B_ROWS = 4,
  parameter int C_DATA_WIDTH     = (2*DATA_WIDTH)+$clog2(A_COLUMNS_B_ROWS)
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic                         valid_i,
  input  logic [C_DATA_WIDTH-1:0]      c_i [A_ROWS*B_COLUMNS],
  output logic                         m_valid_o,
  input  logic                         m_ready_i,
  output logic [C_DATA_WIDTH-1:0]      m_data_o,
  output logic [$clog2(A_ROWS)-1:0]    m_row_o,
  output logic [$clog2(B_COLUMNS)-1:0] m_col_o,
  output logic                         m_last_row_o,
  output logic                         m_last_o,
  output logic                         busy_o,
  output logic                         overflow_o,
  output logic [7:0]                   drop_count_o
);

  localparam int N     = A_ROWS*B_COLUMNS;
  localparam int ROW_W = $clog2(A_ROWS);
  localparam int COL_W = $clog2(B_COLUMNS);
  localparam int IDX_W = $clog2(N);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(A_ROWS-1);
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(B_COLUMNS-1);

  typedef enum logic {IDLE, STREAM} state_t;

  state_t                   state, state_next;
  logic [1:0]               occ, occ_next;
  logic                     wr_ptr, rd_ptr;
  logic [ROW_W-1:0]         row;
  logic [COL_W-1:0]         col;
  logic [IDX_W-1:0]         idx;
  logic [C_DATA_WIDTH-1:0]  bank [2][N];

  logic at_last_row, at_last_col;
  logic handshake, release_bank, accept;

  assign at_last_row  = (row == LAST_ROW);
  assign at_last_col  = (col == LAST_COL);
  assign handshake    = (state == STREAM) && m_ready_i;
  assign release_bank = handshake && at_last_row && at_last_col;
  // A full buffer can still take a matrix if the read bank frees up on this very edge.
  assign accept       = valid_i && ((occ != 2'd2) || release_bank);

  always_comb begin
    occ_next = occ;
    if (accept && !release_bank)
      occ_next = occ + 2'd1;
    else if (!accept && release_bank)
      occ_next = occ - 2'd1;
  end

  always_comb begin
    state_next   = state;
    m_valid_o    = 1'b0;
    m_data_o     = '0;
    m_row_o      = '0;
    m_col_o      = '0;
    m_last_row_o = 1'b0;
    m_last_o     = 1'b0;
    case (state)
      IDLE: begin
        if (accept)
          state_next = STREAM;
      end
      STREAM: begin
        m_valid_o    = 1'b1;
        m_data_o     = bank[rd_ptr][idx];
        m_row_o      = row;
        m_col_o      = col;
        m_last_row_o = at_last_col;
        m_last_o     = at_last_row && at_last_col;
        if (release_bank && (occ_next == 2'd0))
          state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i)
      state <= IDLE;
    else
      state <= state_next;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      occ          <= 2'd0;
      wr_ptr       <= 1'b0;
      rd_ptr       <= 1'b0;
      row          <= '0;
      col          <= '0;
      idx          <= '0;
      busy_o       <= 1'b0;
      overflow_o   <= 1'b0;
      drop_count_o <= 8'd0;
    end else begin
      occ    <= occ_next;
      busy_o <= (occ_next != 2'd0);
      if (accept)
        wr_ptr <= ~wr_ptr;
      if (valid_i && !accept) begin
        overflow_o <= 1'b1;
        if (drop_count_o != 8'hFF)
          drop_count_o <= drop_count_o + 8'd1;
      end
      if (handshake) begin
        if (release_bank) begin
          rd_ptr <= ~rd_ptr;
          row    <= '0;
          col    <= '0;
          idx    <= '0;
        end else begin
          idx <= idx + IDX_W'(1);
          if (at_last_col) begin
            col <= '0;
            row <= row + ROW_W'(1);
          end else begin
            col <= col + COL_W'(1);
          end
        end
      end
    end
  end

  // Bank storage is deliberately left out of reset; occupancy alone says what is valid.
  always_ff @(posedge clk_i) begin
    if (accept) begin
      for (int i = 0; i < N; i++)
        bank[wr_ptr][i] <= c_i[i];
    end
  end

endmodule

// File: tb/tb_matrix_result_serializer.sv
// Directed bench for matrix_result_serializer: inputs change and outputs are
// checked on the falling edge, away from the capturing rising edge.
module tb_matrix_result_serializer;

  localparam int ROWS = 8;
  localparam int COLS = 5;
  localparam int N    = ROWS*COLS;
  localparam int CW   = 18;

  logic          clk_i = 1'b0;
  logic          reset_i;
  logic          valid_i;
  logic [CW-1:0] c_i [N];
  logic          m_valid_o;
  logic          m_ready_i;
  logic [CW-1:0] m_data_o;
  logic [2:0]    m_row_o;
  logic [2:0]    m_col_o;
  logic          m_last_row_o;
  logic          m_last_o;
  logic          busy_o;
  logic          overflow_o;
  logic [7:0]    drop_count_o;

  int total  = 0;
  int passed = 0;

  matrix_result_serializer dut (
    .clk_i(clk_i), .reset_i(reset_i), .valid_i(valid_i), .c_i(c_i),
    .m_valid_o(m_valid_o), .m_ready_i(m_ready_i), .m_data_o(m_data_o),
    .m_row_o(m_row_o), .m_col_o(m_col_o), .m_last_row_o(m_last_row_o),
    .m_last_o(m_last_o), .busy_o(busy_o), .overflow_o(overflow_o),
    .drop_count_o(drop_count_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_valid"}, {31'd0, m_valid_o}, 0);
    check({tag, "_busy"}, {31'd0, busy_o}, 0);
    check({tag, "_last"}, {31'd0, m_last_o}, 0);
    check({tag, "_data"}, {14'd0, m_data_o}, 0);
  endtask

  // Expected element k of a matrix: row-major position, markers on column 4 / element 39.
  task automatic check_beat(input string tag, input int k, input int exp_data);
    string t;
    t = $sformatf("%s_k%0d", tag, k);
    check({t, "_valid"}, {31'd0, m_valid_o}, 1);
    check({t, "_data"}, {14'd0, m_data_o}, exp_data);
    check({t, "_row"}, {29'd0, m_row_o}, k / COLS);
    check({t, "_col"}, {29'd0, m_col_o}, k % COLS);
    check({t, "_lastrow"}, {31'd0, m_last_row_o}, ((k % COLS) == COLS-1) ? 1 : 0);
    check({t, "_last"}, {31'd0, m_last_o}, (k == N-1) ? 1 : 0);
  endtask

  // One-cycle valid_i pulse with c_i[idx] = base + idx (or a flat value).
  task automatic pulse_valid(input int base, input bit flat);
    for (int i = 0; i < N; i++)
      c_i[i] = flat ? CW'(base) : CW'(base + i);
    valid_i = 1'b1;
    @(negedge clk_i);
    valid_i = 1'b0;
  endtask

  // Stream n beats with m_ready_i held high; matrix m uses bases[m].
  task automatic stream(input string tag, input int n, input int b0, input int b1,
                        input int b2, input bit flat);
    int bases [3];
    bases = '{b0, b1, b2};
    m_ready_i = 1'b1;
    for (int k = 0; k < n; k++) begin
      check_beat($sformatf("%s_m%0d", tag, k / N), k % N,
                 flat ? b0 : bases[k / N] + (k % N));
      @(negedge clk_i);
    end
  endtask

  task automatic do_reset();
    reset_i   = 1'b1;
    valid_i   = 1'b0;
    m_ready_i = 1'b0;
    repeat (2) @(negedge clk_i);
    reset_i = 1'b0;
    @(negedge clk_i);
  endtask

  initial begin
    int k;
    int cyc;
    bit rdy;
    for (int i = 0; i < N; i++) c_i[i] = '0;

    // Reset state
    do_reset();
    check_idle("reset");
    check("reset_ovf", {31'd0, overflow_o}, 0);
    check("reset_drop", {24'd0, drop_count_o}, 0);

    // Single matrix, ready always high: element 0 in the cycle after capture
    m_ready_i = 1'b1;
    pulse_valid(1, 1'b0);
    check("single_busy", {31'd0, busy_o}, 1);
    stream("single", N, 1, 0, 0, 1'b0);
    check_idle("single_end");

    // Ready high one cycle in three: same sequence, outputs held during stalls
    pulse_valid(1, 1'b0);
    k = 0;
    cyc = 0;
    while (k < N && cyc < 200) begin
      rdy = (cyc % 3 == 2);
      m_ready_i = rdy;
      check_beat("stall", k, k + 1);
      @(negedge clk_i);
      if (rdy) k++;
      cyc++;
    end
    check("stall_beats", k, N);
    check("stall_cycles", cyc, 120);
    check_idle("stall_end");

    // Overflow: three captures with no drain, the third is dropped
    m_ready_i = 1'b0;
    pulse_valid(100, 1'b0);
    pulse_valid(200, 1'b0);
    pulse_valid(300, 1'b0);
    check("ovf_flag", {31'd0, overflow_o}, 1);
    check("ovf_drop", {24'd0, drop_count_o}, 1);
    check("ovf_busy", {31'd0, busy_o}, 1);
    stream("ovf", 2*N, 100, 200, 0, 1'b0);
    check_idle("ovf_end");
    check("ovf_sticky", {31'd0, overflow_o}, 1);

    // Capture coinciding with the final handshake of a full buffer is accepted
    do_reset();
    pulse_valid(400, 1'b0);
    pulse_valid(500, 1'b0);
    stream("edge_a", N-1, 400, 0, 0, 1'b0);
    check_beat("edge_final", N-1, 400 + N-1);
    pulse_valid(600, 1'b0);
    check("edge_ovf", {31'd0, overflow_o}, 0);
    check("edge_drop", {24'd0, drop_count_o}, 0);
    stream("edge_b", 2*N, 500, 600, 0, 1'b0);
    check_idle("edge_end");

    // Full-width values pass through untouched
    pulse_valid(260100, 1'b1);
    stream("max", N, 260100, 0, 0, 1'b1);
    check_idle("max_end");

    // Asynchronous reset in the middle of a matrix
    pulse_valid(1, 1'b0);
    stream("pre_rst", 17, 1, 0, 0, 1'b0);
    check_beat("pre_rst", 17, 18);
    #2 reset_i = 1'b1;
    #1;
    check_idle("async_rst");
    @(negedge clk_i);
    reset_i = 1'b0;
    @(negedge clk_i);
    check_idle("post_rst");
    pulse_valid(1, 1'b0);
    stream("post_rst", N, 1, 0, 0, 1'b0);
    check_idle("post_rst_end");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
